// File: rtl/serial_rx4.sv
// serial_rx4: receiver for a framed 4-bit serial word.
// Frame: start(1), 4 data bits, even parity, stop(0), sampled on ENB strobes.
// The bit order (DIR) is captured at the start bit and held for the whole frame.
module serial_rx4 (
  input  logic       clk,
  input  logic       RST,
  input  logic       ENB,
  input  logic       DIR,
  input  logic       S_IN,
  output logic [3:0] Q,
  output logic       VALID,
  output logic       PERR,
  output logic       FERR,
  output logic       BUSY,
  output logic [3:0] ERR_CNT
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // Even parity over the four data bits.
  function automatic logic parity4(input logic [3:0] d);
    parity4 = d[0] ^ d[1] ^ d[2] ^ d[3];
  endfunction

  // Shift one serial bit into the data register.
  // LSB first shifts right so the first bit lands in bit 0;
  // MSB first shifts left so the first bit lands in bit 3.
  function automatic logic [3:0] shift_in(input logic [3:0] d, input logic b, input logic msb_first);
    if (msb_first) begin
      shift_in = {d[2:0], b};
    end else begin
      shift_in = {b, d[3:1]};
    end
  endfunction

  logic [1:0] state_r, state_s;
  logic [1:0] cnt_r, cnt_s;
  logic [3:0] data_r, data_s;
  logic       dir_r, dir_s;
  logic       par_r, par_s;
  logic       busy_r;
  logic [3:0] q_r;
  logic       valid_r, perr_r, ferr_r;
  logic [3:0] err_cnt_r;
  logic       good_s, perr_s, ferr_s;

  // Next-state and frame evaluation; nothing moves unless ENB strobes.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    dir_s   = dir_r;
    par_s   = par_r;
    good_s  = 1'b0;
    perr_s  = 1'b0;
    ferr_s  = 1'b0;
    if (ENB) begin
      case (state_r)
        IDLE: begin
          if (S_IN) begin
            dir_s   = DIR;
            cnt_s   = 2'd0;
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end
        DATA: begin
          data_s = shift_in(data_r, S_IN, dir_r);
          cnt_s  = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_s = PARITY;
          end else begin
            state_s = DATA;
          end
        end
        PARITY: begin
          par_s   = S_IN;
          state_s = STOP;
        end
        STOP: begin
          state_s = IDLE;
          if (S_IN) begin
            ferr_s = 1'b1;
          end else if (par_r != parity4(data_r)) begin
            perr_s = 1'b1;
          end else begin
            good_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Frame-tracking registers: state, bit counter, data, parity and latched bit order.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      data_r  <= 4'd0;
      dir_r   <= 1'b0;
      par_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      dir_r   <= dir_s;
      par_r   <= par_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Result registers: one-cycle status pulses, received word and saturating error count.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      q_r       <= 4'd0;
      valid_r   <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      err_cnt_r <= 4'd0;
    end else begin
      valid_r <= good_s;
      perr_r  <= perr_s;
      ferr_r  <= ferr_s;
      if (good_s) begin
        q_r <= data_r;
      end
      if ((perr_s || ferr_s) && (err_cnt_r != 4'hF)) begin
        err_cnt_r <= err_cnt_r + 4'd1;
      end
    end
  end

  assign Q       = q_r;
  assign VALID   = valid_r;
  assign PERR    = perr_r;
  assign FERR    = ferr_r;
  assign BUSY    = busy_r;
  assign ERR_CNT = err_cnt_r;

endmodule

// File: tb/tb_serial_rx4.sv
// tb_serial_rx4: directed frames; expected pulses go into a scoreboard queue
// that a negedge monitor drains whenever the receiver reports a frame result.
module tb_serial_rx4;

  logic       clk = 1'b0;
  logic       RST;
  logic       ENB;
  logic       DIR;
  logic       S_IN;
  logic [3:0] Q;
  logic       VALID;
  logic       PERR;
  logic       FERR;
  logic       BUSY;
  logic [3:0] ERR_CNT;

  serial_rx4 dut (
    .clk(clk), .RST(RST), .ENB(ENB), .DIR(DIR), .S_IN(S_IN),
    .Q(Q), .VALID(VALID), .PERR(PERR), .FERR(FERR), .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  always #5 clk = ~clk;

  // kind = {VALID, PERR, FERR}
  typedef struct {
    logic [2:0] kind;
    logic [3:0] q;
    logic [3:0] err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Free-running cycle count used to check pulse timing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every reported frame result must match the oldest expectation.
  always @(negedge clk) begin
    if ((VALID | PERR | FERR) !== 1'b0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got VALID=%b PERR=%b FERR=%b expected no pulse", VALID, PERR, FERR);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {29'd0, VALID, PERR, FERR}, {29'd0, mon_e.kind});
        chk("q_on_pulse", {28'd0, Q}, {28'd0, mon_e.q});
        chk("err_cnt_on_pulse", {28'd0, ERR_CNT}, {28'd0, mon_e.err});
        chk("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One ENB strobe carrying bit b, preceded by gap cycles with ENB low
  // and S_IN driven to the opposite value to prove it is ignored.
  task automatic drive_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      ENB  = 1'b0;
      S_IN = ~b;
    end
    @(negedge clk);
    ENB  = 1'b1;
    S_IN = b;
    @(posedge clk);
    #1;
  endtask

  // Whole frame, b[6] sent first. flip toggles DIR right after the start bit.
  task automatic send_frame(input logic d, input logic flip, input logic [6:0] b, input int gap,
                            input logic [2:0] kind, input logic [3:0] q, input logic [3:0] err);
    DIR = d;
    drive_bit(b[6], gap);
    chk("busy_in_frame", {31'd0, BUSY}, 32'd1);
    if (flip) DIR = ~d;
    for (int i = 5; i >= 0; i--) drive_bit(b[i], gap);
    sb.push_back('{kind, q, err, cyc});
    chk("busy_after_frame", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    RST  = 1'b1;
    ENB  = 1'b0;
    DIR  = 1'b0;
    S_IN = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_q", {28'd0, Q}, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_err_cnt", {28'd0, ERR_CNT}, 32'd0);
    chk("reset_pulses", {29'd0, VALID, PERR, FERR}, 32'd0);
    RST = 1'b0;

    // Idle line keeps the receiver idle.
    drive_bit(1'b0, 0);
    drive_bit(1'b0, 0);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);

    // 0xA LSB first, then back-to-back 0xC MSB first with DIR toggled mid-frame.
    send_frame(1'b0, 1'b0, 7'b1010100, 0, 3'b100, 4'hA, 4'd0);
    send_frame(1'b1, 1'b1, 7'b1110000, 0, 3'b100, 4'hC, 4'd0);
    // 0x7 with wrong parity, then good 0xA with stop bit 1.
    send_frame(1'b0, 1'b0, 7'b1111000, 0, 3'b010, 4'hC, 4'd1);
    send_frame(1'b0, 1'b0, 7'b1010101, 0, 3'b001, 4'hC, 4'd2);
    // Further error frames drive the count into saturation.
    for (int k = 3; k <= 17; k++) begin
      if (k[0]) send_frame(1'b0, 1'b0, 7'b1111000, 0, 3'b010, 4'hC, (k > 15) ? 4'd15 : 4'(k));
      else      send_frame(1'b0, 1'b0, 7'b1010101, 0, 3'b001, 4'hC, (k > 15) ? 4'd15 : 4'(k));
    end
    chk("err_cnt_saturated", {28'd0, ERR_CNT}, 32'd15);

    // 0x5 LSB first with three ENB-low cycles before every bit.
    drive_bit(1'b0, 0);
    send_frame(1'b0, 1'b0, 7'b1101000, 3, 3'b100, 4'h5, 4'd15);

    // Abort a 0x3 frame after two data bits with reset.
    DIR = 1'b0;
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    @(negedge clk);
    ENB  = 1'b0;
    S_IN = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("midframe_reset_busy", {31'd0, BUSY}, 32'd0);
    chk("midframe_reset_q", {28'd0, Q}, 32'd0);
    chk("midframe_reset_err_cnt", {28'd0, ERR_CNT}, 32'd0);
    @(negedge clk);
    RST = 1'b0;
    send_frame(1'b0, 1'b0, 7'b1110000, 0, 3'b100, 4'h3, 4'd0);

    @(negedge clk);
    ENB = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("final_q", {28'd0, Q}, 32'd3);
    chk("final_busy", {31'd0, BUSY}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx4.md
SERIAL_RX4 -- requirements
Module: serial_rx4

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ENB  input  1  bit-time strobe; S_IN is sampled only on clk edges where ENB=1.
REQ-004 SHALL have port: DIR  input  1  bit order (0 = LSB first, 1 = MSB first), matching the shift-register shift direction.
REQ-005 SHALL have port: S_IN  input  1  serial line, driven by the shift register S_OUT; idles at 0.
REQ-006 SHALL have port: Q  output  4  last correctly received nibble.
REQ-007 SHALL have port: VALID  output  1  one-cycle pulse; Q is updated with a good frame.
REQ-008 SHALL have port: PERR  output  1  one-cycle pulse; parity mismatch.
REQ-009 SHALL have port: FERR  output  1  one-cycle pulse; stop bit is not 0.
REQ-010 SHALL have port: BUSY  output  1  high while a frame is in progress (any state except IDLE).
REQ-011 SHALL have port: ERR_CNT  output  4  saturating count of PERR and FERR events.

Function
REQ-012 Frame, in ENB-strobed bit times: start (1), 4 data bits, even-parity bit, stop (0); 7 sampled bits total.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY and STOP; all transitions occur only on clk edges with ENB=1.
REQ-014 IDLE: if S_IN=1, latch DIR into an internal dir register, clear the bit counter and go to DATA; otherwise stay in IDLE.
REQ-015 DATA: on each strobe, shift S_IN into the data register.
  - Latched dir=0: the first received bit goes to bit 0.
  - Latched dir=1: the first received bit goes to bit 3.
  - After the 4th bit, go to PARITY.
REQ-016 The DIR input SHALL be ignored after the start bit; a change mid-frame has no effect on that frame.
REQ-017 PARITY: capture S_IN and go to STOP; expected parity = XOR of the 4 data bits.
REQ-018 STOP: go to IDLE and evaluate the frame.
  - Stop bit = 1: pulse FERR; Q unchanged; no VALID, no PERR.
  - Else parity mismatch: pulse PERR; Q unchanged; no VALID.
  - Else: load Q and pulse VALID.
REQ-019 VALID, PERR and FERR SHALL be registered, high exactly one clk cycle following the stop-sampling edge, and mutually exclusive.
REQ-020 ENB=0 SHALL freeze state, counter and data register; outputs other than the one-cycle pulses SHALL hold.
REQ-021 Back-to-back frames: a start bit on the strobe immediately after a stop strobe SHALL be accepted with no idle gap required.
REQ-022 ERR_CNT SHALL increment by 1 per PERR or FERR, saturate at 15 and never wrap.
REQ-023 Latency: Q and VALID update on the 7th strobe edge of a frame.

Reset
REQ-024 RST=1 SHALL immediately force IDLE, with Q=0, VALID=0, PERR=0, FERR=0, BUSY=0, ERR_CNT=0, data register and counter cleared, and dir=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception restarts on the next start bit.
REQ-026 Reset release SHALL take effect at the first clk edge after deassertion.

Verification
REQ-027 DIR=0, ENB=1 every cycle, S_IN = 1,0,1,0,1,0,0 -> Q=4'hA, VALID single pulse, BUSY low afterward.
REQ-028 DIR=1, S_IN = 1,1,1,0,0,0,0 -> Q=4'hC, VALID single pulse; a DIR toggle during data bits does not change the result.
REQ-029 DIR=0, S_IN = 1,1,1,1,0,0,0 (data 0x7, wrong parity) -> PERR pulse, Q holds the previous value, ERR_CNT=1.
REQ-030 Good 0xA frame with stop bit 1 -> FERR pulse, no VALID, ERR_CNT increments; 16 error frames -> ERR_CNT=15.
REQ-031 ENB low for 3 cycles between each bit of a 0x5 LSB-first frame -> Q=4'h5; VALID only on the 7th strobe.
REQ-032 RST pulsed after the 2nd data bit, then a full 0x3 frame -> no pulse from the aborted frame, Q=4'h3, ERR_CNT=0.
